ram_access_scheduler: RTL and testbench
=======================================

// Module: ram_access_scheduler
// PURPOSE
//  Sequences and shares the 8x8x16 matrix RAM between two requesters: a word writer (loader) and a row
//  reader (compute engine). Round-robin arbitrates one grant per cycle, drives the RAM write and row-select
//  pins, and flags when the RAM row output is valid. Also runs a 64-cycle zero-fill sweep after reset or on demand.
// PARAMETERS
//  ADDR_W          3   row/column index width (RAM is 2**ADDR_W x 2**ADDR_W words)
//  DATA_W          16  word width
//  CLEAR_ON_RESET  1   1: zero-fill sweep starts on reset release; 0: start in SERVE
// PORTS
//  clock          in   1       single clock; all state changes on rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  clear_req      in   1       pulse: start zero-fill sweep (ignored while busy)
//  busy           out  1       high while sweeping; both readies held low
//  wr_valid       in   1       writer request
//  wr_ready       out  1       writer grant (accept = wr_valid & wr_ready)
//  wr_i, wr_j     in   ADDR_W  target row, column
//  wr_data        in   DATA_W  word to write
//  rd_valid       in   1       reader request
//  rd_ready       out  1       reader grant
//  rd_row         in   ADDR_W  row to read
//  rd_resp_valid  out  1       one-cycle pulse: RAM row output holds row rd_resp_row
//  rd_resp_row    out  ADDR_W  row index of current response
//  ram_wen        out  1       RAM write enable
//  ram_wi, ram_wj out  ADDR_W  RAM write address
//  ram_wdata      out  DATA_W  RAM write data
//  ram_ri         out  ADDR_W  RAM read row select (column read select tied 0 at top level)
// BEHAVIOUR
//  - All outputs except wr_ready/rd_ready are registered. Reset values: ram_wen=0, ram_wi/wj/wdata/ri=0,
//    rd_resp_valid=0, rd_resp_row=0, busy=CLEAR_ON_RESET, rr priority = writer; state = CLEAR or SERVE.
//  - States: CLEAR (sweep), SERVE (arbitrate). CLEAR->SERVE after the 64th zero write is issued;
//    SERVE->CLEAR on clear_req (clear_req wins over any pending request that cycle; no grant issued).
//  - CLEAR: 6-bit counter cnt from 0; each cycle register ram_wen=1, ram_wi=cnt[5:3], ram_wj=cnt[2:0],
//    ram_wdata=0; cnt++. After cnt=63 issued: ram_wen=0 next cycle, busy falls same edge. rd_resp_valid=0.
//  - SERVE grants (combinational): only one of wr_ready/rd_ready high per cycle, never when busy.
//    Only-one-valid -> that one granted. Both valid -> side not granted last time; priority flag flips
//    to the other side after each grant. Ready depends on valid; requesters hold valid+payload until accepted.
//  - Write accept at edge E: ram_wen=1 with registered wi/wj/wdata for one cycle; word lands at E+1.
//    No write accept -> ram_wen=0.
//  - Read accept at edge E: ram_ri<=rd_row, rd_resp_row<=rd_row, rd_resp_valid=1 for the cycle after E.
//    ram_ri holds until the next read accept. Latency request->row data = 1 cycle.
//  - Ordering: write accepted at E, read of same row accepted at E+1 returns new data (written at E+1).
//    No further hazard logic needed.
//  - Reset mid-operation (asserted anywhere, incl. mid-sweep): immediate return to reset values.
//    Sweep restarts from cnt=0 on release if CLEAR_ON_RESET=1. Granted-but-unissued work is dropped.
// STRUCTURE
//  - Package ram_ctrl_pkg: state enum {ST_CLEAR, ST_SERVE}, ADDR_W/DATA_W defaults, WORDS=64 constant.
//  - Sub-module rr_arbiter_2: 2-requester round-robin (req[1:0], gnt[1:0], advance) with a priority flop.
//    Top level holds FSM, sweep counter and RAM-pin registers.
// TESTING
//  1. Reset release, CLEAR_ON_RESET=1 -> 64 consecutive ram_wen cycles over (0,0)..(7,7), wdata=0; busy low
//     on the edge after the last; readies low throughout.
//  2. wr_valid, (i,j)=(3,5), data=16'hBEEF -> wr_ready same cycle; next cycle ram_wen=1, wi=3, wj=5,
//     wdata=BEEF; then read row 3 -> rd_resp_valid one cycle later, word 5 = BEEF.
//  3. wr_valid and rd_valid held together for 6 cycles -> grants alternate W,R,W,R,W,R starting with writer.
//  4. Write (2,0)=16'h0001 accepted at E, read row 2 accepted at E+1 -> response shows word 0 = 0001.
//  5. reset_n low at sweep cnt=20 for 2 cycles -> outputs at reset values; sweep restarts at (0,0).
//  6. clear_req with wr_valid high in SERVE -> no write grant; busy=1 next cycle, full 64-word sweep,
//     then the pending write is granted.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the matrix RAM access scheduler.
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 16;
    localparam int WORDS      = 64;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/ram_access_scheduler_arb.sv
// Two-requester round-robin arbiter: bit 0 is the writer, bit 1 the reader.
module rr_arbiter_2
    import ram_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // prio_q = 0 favours the writer on a tie, 1 favours the reader
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (advance && (gnt != 2'b00)) begin
            prio_d = gnt[0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_access_scheduler.sv
// Shares the matrix RAM between a word writer and a row reader, with a zero-fill
// sweep after reset or on request. All RAM pins and status outputs are registered.
module ram_access_scheduler
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_i,
    input  logic [ADDR_W-1:0] wr_j,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_row,
    output logic              rd_resp_valid,
    output logic [ADDR_W-1:0] rd_resp_row,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_wi,
    output logic [ADDR_W-1:0] ram_wj,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_ri
);

    localparam int               CNT_W    = 2 * ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
    localparam state_t           ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                ram_wen_q, ram_wen_d;
    logic [ADDR_W-1:0]   ram_wi_q, ram_wi_d;
    logic [ADDR_W-1:0]   ram_wj_q, ram_wj_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0]   ram_ri_q, ram_ri_d;
    logic                rd_resp_valid_q, rd_resp_valid_d;
    logic [ADDR_W-1:0]   rd_resp_row_q, rd_resp_row_d;

    logic       serve_open;
    logic       clear_take;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;

    // busy_q lingers one cycle past the sweep, so grants reopen only once the last zero write has landed
    assign serve_open = (state_q == ST_SERVE) && !busy_q;
    assign clear_take = serve_open && clear_req;
    assign arb_req    = {rd_valid, wr_valid} & {2{serve_open && !clear_req}};

    rr_arbiter_2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (arb_req),
        .advance (|arb_gnt),
        .gnt     (arb_gnt)
    );

    assign wr_ready = arb_gnt[0];
    assign rd_ready = arb_gnt[1];

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ram_wen_d       = 1'b0;
        ram_wi_d        = ram_wi_q;
        ram_wj_d        = ram_wj_q;
        ram_wdata_d     = ram_wdata_q;
        ram_ri_d        = ram_ri_q;
        rd_resp_valid_d = 1'b0;
        rd_resp_row_d   = rd_resp_row_q;

        case (state_q)
            ST_CLEAR: begin
                ram_wen_d   = 1'b1;
                ram_wi_d    = cnt_q[CNT_W-1:ADDR_W];
                ram_wj_d    = cnt_q[ADDR_W-1:0];
                ram_wdata_d = '0;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (clear_take) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    if (arb_gnt[0]) begin
                        ram_wen_d   = 1'b1;
                        ram_wi_d    = wr_i;
                        ram_wj_d    = wr_j;
                        ram_wdata_d = wr_data;
                    end
                    if (arb_gnt[1]) begin
                        ram_ri_d        = rd_row;
                        rd_resp_row_d   = rd_row;
                        rd_resp_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase

        busy_d = (state_d == ST_CLEAR) || (state_q == ST_CLEAR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_RESET;
            cnt_q           <= '0;
            busy_q          <= CLEAR_ON_RESET;
            ram_wen_q       <= 1'b0;
            ram_wi_q        <= '0;
            ram_wj_q        <= '0;
            ram_wdata_q     <= '0;
            ram_ri_q        <= '0;
            rd_resp_valid_q <= 1'b0;
            rd_resp_row_q   <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            busy_q          <= busy_d;
            ram_wen_q       <= ram_wen_d;
            ram_wi_q        <= ram_wi_d;
            ram_wj_q        <= ram_wj_d;
            ram_wdata_q     <= ram_wdata_d;
            ram_ri_q        <= ram_ri_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            rd_resp_row_q   <= rd_resp_row_d;
        end
    end

    assign busy          = busy_q;
    assign ram_wen       = ram_wen_q;
    assign ram_wi        = ram_wi_q;
    assign ram_wj        = ram_wj_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_ri        = ram_ri_q;
    assign rd_resp_valid = rd_resp_valid_q;
    assign rd_resp_row   = rd_resp_row_q;

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Scoreboard bench for ram_access_scheduler: random and directed traffic against a queue/array reference.
module tb_ram_access_scheduler;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int SWEEP_BUSY = 65;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          clear_req;
    logic          busy;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_i, wr_j;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_row;
    logic          rd_resp_valid;
    logic [AW-1:0] rd_resp_row;
    logic          ram_wen;
    logic [AW-1:0] ram_wi, ram_wj;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_ri;

    ram_access_scheduler #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear_req     (clear_req),
        .busy          (busy),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_i          (wr_i),
        .wr_j          (wr_j),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_row        (rd_row),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_row   (rd_resp_row),
        .ram_wen       (ram_wen),
        .ram_wi        (ram_wi),
        .ram_wj        (ram_wj),
        .ram_wdata     (ram_wdata),
        .ram_ri        (ram_ri)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            due;
        logic [AW-1:0] i;
        logic [AW-1:0] j;
        logic [DW-1:0] d;
    } wexp_t;

    typedef struct {
        int            due;
        logic [AW-1:0] row;
        logic [127:0]  data;
    } rexp_t;

    typedef struct {
        logic [AW-1:0] i;
        logic [AW-1:0] j;
        logic [DW-1:0] d;
    } wtx_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wexp_t         wq[$];
    rexp_t         rq[$];
    wtx_t          wtxq[$];
    logic [AW-1:0] rtxq[$];

    logic [DW-1:0] env_mem [8][8];
    logic [DW-1:0] ref_mem [8][8];

    int            busy_left = SWEEP_BUSY;
    bit            sweep_pend = 1'b1;
    bit            prio = 1'b0;
    logic [AW-1:0] exp_ri = '0;
    bit            wacc = 1'b0;
    bit            racc = 1'b0;
    bit            log_en = 1'b0;
    int            grant_log[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] env_row(input logic [AW-1:0] r);
        logic [127:0] v;
        for (int j = 0; j < 8; j++) v[j*16 +: 16] = env_mem[r][j];
        return v;
    endfunction

    function automatic logic [127:0] ref_row(input logic [AW-1:0] r);
        logic [127:0] v;
        for (int j = 0; j < 8; j++) v[j*16 +: 16] = ref_mem[r][j];
        return v;
    endfunction

    task automatic ref_zero();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) ref_mem[i][j] = '0;
    endtask

    task automatic push_sweep(input int first_due);
        wexp_t e;
        for (int k = 0; k < 64; k++) begin
            e.due = first_due + k;
            e.i   = AW'(k / 8);
            e.j   = AW'(k % 8);
            e.d   = '0;
            wq.push_back(e);
        end
    endtask

    // Environment RAM driven by the scheduler's pins
    always @(posedge clock) begin
        if (ram_wen) env_mem[ram_wi][ram_wj] <= ram_wdata;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Reference model: predicts grants, busy and read-select, queues expected RAM-side events
    initial forever begin
        bit    exp_busy, gw, gr;
        wexp_t we;
        rexp_t re;
        @(negedge clock);
        if (!reset_n) begin
            chk("rst_busy", busy, 1);
            chk("rst_readies", {wr_ready, rd_ready}, 0);
            chk("rst_wen", ram_wen, 0);
            chk("rst_resp", {rd_resp_valid, rd_resp_row}, 0);
            chk("rst_pins", {ram_wi, ram_wj, ram_wdata, ram_ri}, 0);
            busy_left  = SWEEP_BUSY;
            sweep_pend = 1'b1;
            prio       = 1'b0;
            exp_ri     = '0;
            wq.delete();
            rq.delete();
            ref_zero();
        end else begin
            exp_busy = (busy_left > 0);
            chk("busy", busy, exp_busy);
            chk("ram_ri_hold", ram_ri, exp_ri);
            if (sweep_pend) begin
                push_sweep(cyc + 1);
                sweep_pend = 1'b0;
            end
            gw = 1'b0;
            gr = 1'b0;
            if (!exp_busy && !clear_req) begin
                if (wr_valid && rd_valid) begin
                    gw = (prio == 1'b0);
                    gr = (prio == 1'b1);
                end else begin
                    gw = wr_valid;
                    gr = rd_valid;
                end
            end
            chk("wr_ready", wr_ready, gw);
            chk("rd_ready", rd_ready, gr);
            if (exp_busy) busy_left--;
            if (!exp_busy && clear_req) begin
                busy_left = SWEEP_BUSY;
                ref_zero();
                push_sweep(cyc + 2);
            end
            if (gw) begin
                ref_mem[wr_i][wr_j] = wr_data;
                we.due = cyc + 1;
                we.i   = wr_i;
                we.j   = wr_j;
                we.d   = wr_data;
                wq.push_back(we);
                prio = 1'b1;
            end
            if (gr) begin
                re.due  = cyc + 1;
                re.row  = rd_row;
                re.data = ref_row(rd_row);
                rq.push_back(re);
                exp_ri = rd_row;
                prio   = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a RAM write or a row response
    initial forever begin
        wexp_t we;
        rexp_t re;
        @(negedge clock);
        if (reset_n) begin
            if (ram_wen) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: ram_wen=1 at (%0d,%0d) data %h, none expected", ram_wi, ram_wj, ram_wdata);
                end else begin
                    we = wq.pop_front();
                    chk("wr_cycle", cyc, we.due);
                    chk("wr_addr", {ram_wi, ram_wj}, {we.i, we.j});
                    chk("wr_data", ram_wdata, we.d);
                end
            end
            while (wq.size() > 0 && wq[0].due < cyc) begin
                we = wq.pop_front();
                chk("wr_missed_cycle", cyc, we.due);
            end
            if (rd_resp_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: rd_resp_valid=1 row %0d, none expected", rd_resp_row);
                end else begin
                    re = rq.pop_front();
                    chk("rd_cycle", cyc, re.due);
                    chk("rd_resp_row", rd_resp_row, re.row);
                    chk("rd_row_data", env_row(ram_ri), re.data);
                end
            end
            while (rq.size() > 0 && rq[0].due < cyc) begin
                re = rq.pop_front();
                chk("rd_missed_cycle", cyc, re.due);
            end
        end
    end

    initial forever begin
        @(negedge clock);
        wacc = reset_n && wr_valid && wr_ready;
        racc = reset_n && rd_valid && rd_ready;
        if (log_en && wacc) grant_log.push_back(0);
        if (log_en && racc) grant_log.push_back(1);
    end

    // Requester drivers: hold valid and payload until accepted
    initial begin
        wtx_t t;
        wr_valid = 1'b0;
        wr_i = '0;
        wr_j = '0;
        wr_data = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                wr_valid = 1'b0;
            end else if (!wr_valid || wacc) begin
                if (wtxq.size() > 0) begin
                    t = wtxq.pop_front();
                    wr_i = t.i;
                    wr_j = t.j;
                    wr_data = t.d;
                    wr_valid = 1'b1;
                end else begin
                    wr_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        rd_valid = 1'b0;
        rd_row = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                rd_valid = 1'b0;
            end else if (!rd_valid || racc) begin
                if (rtxq.size() > 0) begin
                    rd_row = rtxq.pop_front();
                    rd_valid = 1'b1;
                end else begin
                    rd_valid = 1'b0;
                end
            end
        end
    end

    function automatic bit idle();
        return !busy && !wr_valid && !rd_valid && wtxq.size() == 0 && rtxq.size() == 0
               && wq.size() == 0 && rq.size() == 0;
    endfunction

    task automatic wait_idle(input int bound, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!idle() && n < bound);
        if (!idle()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: not idle after %0d cycles", tag, n);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic push_wr(input logic [AW-1:0] i, input logic [AW-1:0] j, input logic [DW-1:0] d);
        wtx_t t;
        t.i = i;
        t.j = j;
        t.d = d;
        wtxq.push_back(t);
    endtask

    initial begin
        int exp3 [6];
        exp3 = '{0, 1, 0, 1, 0, 1};
        reset_n   = 1'b0;
        clear_req = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        wait_idle(200, "sweep_after_reset");

        @(negedge clock);
        push_wr(3'd3, 3'd5, 16'hBEEF);
        wait_idle(50, "write_3_5");
        rtxq.push_back(3'd3);
        wait_idle(50, "read_row_3");

        @(negedge clock);
        log_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_wr(AW'(k), AW'(k + 1), DW'(16'h1000 + k));
            rtxq.push_back(AW'(k + 4));
        end
        wait_idle(50, "alternate");
        log_en = 1'b0;
        chk("alt_count", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk($sformatf("alt_grant_%0d", k), grant_log[k], exp3[k]);

        @(negedge clock);
        push_wr(3'd2, 3'd0, 16'h0001);
        rtxq.push_back(3'd2);
        wait_idle(50, "write_then_read");

        @(posedge clock);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (21) @(posedge clock);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        wait_idle(200, "sweep_after_midreset");

        @(negedge clock);
        push_wr(3'd6, 3'd6, 16'hCAFE);
        @(posedge clock);
        #1 clear_req = 1'b1;
        @(posedge clock);
        #1 clear_req = 1'b0;
        wait_idle(200, "clear_with_pending_write");

        for (int n = 0; n < 400; n++) begin
            @(posedge clock);
            #1;
            clear_req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 2) == 0 && wtxq.size() < 4)
                push_wr(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), DW'($urandom));
            if ($urandom_range(0, 2) == 0 && rtxq.size() < 4)
                rtxq.push_back(AW'($urandom_range(0, 7)));
        end
        @(posedge clock);
        #1 clear_req = 1'b0;
        wait_idle(400, "random_drain");

        @(negedge clock);
        for (int r = 0; r < 8; r++) rtxq.push_back(AW'(r));
        wait_idle(100, "final_readback");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
